// File: rtl/booth_mul_seq_if.sv
// Start/busy/done handshake and product bus for booth_mul_seq.
// The master drives start and operands; the slave returns status and the product halves.
interface booth_mul_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, WIDTH/2+1 steps per product.
// Operands are widened by two bits so signed and unsigned share one datapath.
module booth_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             clr,
    booth_mul_seq_if.slave  bus
);
    localparam int unsigned E    = WIDTH + 2;
    localparam int unsigned A    = E + 1;
    localparam int unsigned PW   = A + E + 1;
    localparam int unsigned N    = WIDTH / 2 + 1;
    localparam int unsigned CntW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [E-1:0]     m_q, m_d;
    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [E-1:0]     a_ext, b_ext;
    logic [A-1:0]     m1, m2, pp, sum;
    logic [PW-1:0]    p_step;

    assign a_ext = bus.is_signed ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
    assign b_ext = bus.is_signed ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};
    assign m1    = {m_q[E-1], m_q};
    assign m2    = {m_q, 1'b0};

    // p_q = {accumulator[A], multiplier[E], guard bit}; the low three bits are the Booth triplet.
    always_comb begin
        pp = '0;
        case (p_q[2:0])
            3'b001, 3'b010: pp = m1;
            3'b011:         pp = m2;
            3'b100:         pp = ~m2 + A'(1);
            3'b101, 3'b110: pp = ~m1 + A'(1);
            default:        pp = '0;
        endcase
    end

    assign sum    = p_q[PW-1 -: A] + pp;
    assign p_step = {{2{sum[A-1]}}, sum, p_q[E:2]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        p_d     = p_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    state_d = StCalc;
                    cnt_d   = '0;
                    m_d     = a_ext;
                    p_d     = {{A{1'b0}}, b_ext, 1'b0};
                end
            end
            StCalc: begin
                p_d   = p_step;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N - 1)) begin
                    state_d = StDone;
                    // Product sits just above the guard bit once the multiplier is shifted out.
                    hi_d    = p_step[2*WIDTH:WIDTH+1];
                    lo_d    = p_step[WIDTH:1];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            m_q     <= '0;
            p_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            p_q     <= p_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == StCalc);
    assign bus.done = (state_q == StDone);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
